// File: rtl/calc_pkg.sv
// Shared types for the 4-bit calculator: opcode enum used by the core and
// the operand sequencer's state encoding (also exported on the phase LEDs).
package calc_pkg;

  localparam int unsigned OP_W    = 2;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [OP_W-1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    OR  = 2'b10,
    NEQ = 2'b11
  } calc_op_t;

  typedef enum logic [STATE_W-1:0] {
    GET_A    = 3'd0,
    GET_B    = 3'd1,
    GET_OP   = 3'd2,
    ISSUE    = 3'd3,
    WAIT_RSP = 3'd4,
    SHOW     = 3'd5
  } seq_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Raw push button to one-cycle press pulse: 2-flop synchronizer, stability
// counter on the synchronized level, then rising-edge detect on the debounced level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       r_sync;
  logic             r_level;
  logic             r_level_d;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= 2'b00;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_pulse   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync    <= {r_sync[0], btn_in};
      r_level_d <= r_level;
      r_pulse   <= r_level & ~r_level_d;
      if (r_sync[1] != r_level) begin
        if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_level <= r_sync[1];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign pulse = r_pulse;

endmodule

// File: rtl/calc_operand_sequencer.sv
// Front-end sequencer: collects A, B and opcode from switches on debounced
// button presses, issues one request to the calculator core and holds the result.
module calc_operand_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  input  logic [1:0]       op_in,
  input  logic             btn_enter,
  input  logic             btn_clear,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [WIDTH-1:0] req_a,
  output logic [WIDTH-1:0] req_b,
  output logic [1:0]       req_op,
  input  logic             rsp_valid,
  input  logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] disp_value,
  output logic [2:0]       phase,
  output logic             busy
);

  logic             w_enter_p;
  logic             w_clear_p;
  logic [WIDTH-1:0] w_disp;

  seq_state_t       r_state;
  logic             r_req_valid;
  logic             r_busy;
  logic [WIDTH-1:0] r_req_a;
  logic [WIDTH-1:0] r_req_b;
  calc_op_t         r_req_op;
  logic [WIDTH-1:0] r_result;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (btn_enter),
    .pulse  (w_enter_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (btn_clear),
    .pulse  (w_clear_p)
  );

  // Sequencer FSM; req_valid/busy are updated on the same edge as the state.
  // Clear is ignored in ISSUE so an offered request is never withdrawn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= GET_A;
      r_req_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_req_a     <= '0;
      r_req_b     <= '0;
      r_req_op    <= ADD;
      r_result    <= '0;
    end else if (w_clear_p && (r_state != ISSUE)) begin
      r_state     <= GET_A;
      r_req_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        GET_A: begin
          if (w_enter_p) begin
            r_req_a <= sw_in;
            r_state <= GET_B;
          end
        end
        GET_B: begin
          if (w_enter_p) begin
            r_req_b <= sw_in;
            r_state <= GET_OP;
          end
        end
        GET_OP: begin
          if (w_enter_p) begin
            r_req_op    <= calc_op_t'(op_in);
            r_state     <= ISSUE;
            r_req_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ISSUE: begin
          if (req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (rsp_valid) begin
            r_result <= rsp_data;
            r_state  <= SHOW;
            r_busy   <= 1'b0;
          end
        end
        SHOW: begin
          if (w_enter_p) begin
            r_state <= GET_A;
          end
        end
        default: begin
          r_state     <= GET_A;
          r_req_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Display source follows the phase so the switches are live while entering.
  always_comb begin
    w_disp = sw_in;
    case (r_state)
      GET_OP:          w_disp = WIDTH'(op_in);
      ISSUE, WAIT_RSP: w_disp = r_req_b;
      SHOW:            w_disp = r_result;
      default:         w_disp = sw_in;
    endcase
  end

  assign req_valid  = r_req_valid;
  assign req_a      = r_req_a;
  assign req_b      = r_req_b;
  assign req_op     = r_req_op;
  assign busy       = r_busy;
  assign phase      = r_state;
  assign disp_value = w_disp;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Directed bench for calc_operand_sequencer with DEBOUNCE_CYCLES=4 and a
// small calculator-core responder with configurable latency and result.
module tb_calc_operand_sequencer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DB    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] sw_in = '0;
  logic [1:0]       op_in = 2'b00;
  logic             btn_enter = 1'b0;
  logic             btn_clear = 1'b0;
  logic             req_valid;
  logic             req_ready = 1'b0;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [1:0]       req_op;
  logic             rsp_valid = 1'b0;
  logic [WIDTH-1:0] rsp_data = '0;
  logic [WIDTH-1:0] disp_value;
  logic [2:0]       phase;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic             core_en = 1'b0;
  int               core_delay = 2;
  logic [WIDTH-1:0] core_data = '0;
  int               hs_cnt = 0;
  int               rsp_done = 0;
  int               vcount = 0;
  int               drop_cnt = 0;
  logic [WIDTH-1:0] hs_a = '0;
  logic [WIDTH-1:0] hs_b = '0;
  logic [1:0]       hs_op = '0;

  calc_operand_sequencer #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_in      (sw_in),
    .op_in      (op_in),
    .btn_enter  (btn_enter),
    .btn_clear  (btn_clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .disp_value (disp_value),
    .phase      (phase),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Monitors: count valid cycles and valid drops while in ISSUE.
  always @(negedge clk) begin
    if (req_valid === 1'b1) vcount++;
    if (phase === 3'd3 && req_valid !== 1'b1) drop_cnt++;
  end

  // Core responder: records each handshake, answers core_delay edges later.
  always begin
    @(negedge clk);
    if (req_valid === 1'b1 && req_ready === 1'b1) begin
      hs_cnt++;
      hs_a  = req_a;
      hs_b  = req_b;
      hs_op = req_op;
      if (core_en) begin
        @(posedge clk);
        repeat (core_delay - 1) @(posedge clk);
        #1;
        rsp_valid = 1'b1;
        rsp_data  = core_data;
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        rsp_done++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic e, input logic c);
    btn_enter = e;
    btn_clear = c;
    tick(10);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    tick(10);
  endtask

  task automatic test_reset;
    sw_in = 4'h7;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase got %0d exp 0", phase); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", req_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (req_a !== 4'h0 || req_b !== 4'h0 || req_op !== 2'b00) begin
      errors++; $display("FAIL reset_regs got a=%h b=%h op=%b exp 0/0/00", req_a, req_b, req_op); end
    checks++; if (disp_value !== 4'h7) begin errors++; $display("FAIL reset_disp got %h exp 7", disp_value); end
  endtask

  task automatic test_full_sequence;
    int v0;
    int h0;
    v0 = vcount;
    h0 = hs_cnt;
    core_en = 1'b1; core_delay = 2; core_data = 4'h8; req_ready = 1'b1;
    sw_in = 4'h3; press(1'b1, 1'b0);
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL seq_get_b got %0d exp 1", phase); end
    sw_in = 4'h5; press(1'b1, 1'b0);
    checks++; if (phase !== 3'd2) begin errors++; $display("FAIL seq_get_op got %0d exp 2", phase); end
    op_in = 2'b11;
    #1;
    checks++; if (disp_value !== 4'h3) begin errors++; $display("FAIL seq_op_disp got %h exp 3", disp_value); end
    op_in = 2'b00;
    press(1'b1, 1'b0);
    checks++; if (phase !== 3'd5) begin errors++; $display("FAIL seq_show got %0d exp 5", phase); end
    checks++; if (disp_value !== 4'h8) begin errors++; $display("FAIL seq_result got %h exp 8", disp_value); end
    checks++; if (hs_cnt - h0 !== 1) begin errors++; $display("FAIL seq_handshakes got %0d exp 1", hs_cnt - h0); end
    checks++; if (vcount - v0 !== 1) begin errors++; $display("FAIL seq_valid_cycles got %0d exp 1", vcount - v0); end
    checks++; if (hs_a !== 4'h3 || hs_b !== 4'h5 || hs_op !== 2'b00) begin
      errors++; $display("FAIL seq_payload got a=%h b=%h op=%b exp 3/5/00", hs_a, hs_b, hs_op); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL seq_busy got %0b exp 0", busy); end
    sw_in = 4'hC;
    press(1'b1, 1'b0);
    checks++; if (phase !== 3'd0 || disp_value !== 4'hC) begin
      errors++; $display("FAIL seq_restart got phase=%0d disp=%h exp 0/c", phase, disp_value); end
  endtask

  task automatic test_debounce;
    sw_in = 4'hC;
    for (int i = 0; i < 5; i++) begin
      btn_enter = 1'b1; tick(2);
      btn_enter = 1'b0; tick(2);
    end
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL db_bounce got %0d exp 0", phase); end
    btn_enter = 1'b1;
    tick(7);
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL db_early got %0d exp 0", phase); end
    tick(1);
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL db_advance got %0d exp 1", phase); end
    tick(12);
    btn_enter = 1'b0;
    tick(10);
    checks++; if (phase !== 3'd1 || req_a !== 4'hC) begin
      errors++; $display("FAIL db_single got phase=%0d a=%h exp 1/c", phase, req_a); end
  endtask

  task automatic test_simultaneous;
    sw_in = 4'h9;
    press(1'b1, 1'b1);
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL simul_phase got %0d exp 0", phase); end
    checks++; if (req_b !== 4'h5) begin errors++; $display("FAIL simul_req_b got %h exp 5", req_b); end
  endtask

  task automatic test_backpressure;
    int d0;
    int h0;
    core_en = 1'b0; req_ready = 1'b0;
    sw_in = 4'h6; press(1'b1, 1'b0);
    sw_in = 4'hA; press(1'b1, 1'b0);
    op_in = 2'b10; press(1'b1, 1'b0);
    checks++; if (phase !== 3'd3 || req_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL bp_issue got phase=%0d valid=%0b busy=%0b exp 3/1/1", phase, req_valid, busy); end
    checks++; if (disp_value !== 4'hA) begin errors++; $display("FAIL bp_disp got %h exp a", disp_value); end
    d0 = drop_cnt;
    h0 = hs_cnt;
    sw_in = 4'h1; op_in = 2'b01;
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    checks++; if (phase !== 3'd3 || req_valid !== 1'b1) begin
      errors++; $display("FAIL bp_hold got phase=%0d valid=%0b exp 3/1", phase, req_valid); end
    checks++; if (req_a !== 4'h6 || req_b !== 4'hA || req_op !== 2'b10) begin
      errors++; $display("FAIL bp_stable got a=%h b=%h op=%b exp 6/a/10", req_a, req_b, req_op); end
    checks++; if (drop_cnt - d0 !== 0) begin errors++; $display("FAIL bp_drop got %0d exp 0", drop_cnt - d0); end
    req_ready = 1'b1;
    tick(1);
    req_ready = 1'b0;
    checks++; if (phase !== 3'd4 || req_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL bp_handshake got phase=%0d valid=%0b busy=%0b exp 4/0/1", phase, req_valid, busy); end
    checks++; if (hs_cnt - h0 !== 1) begin errors++; $display("FAIL bp_hs_count got %0d exp 1", hs_cnt - h0); end
  endtask

  task automatic test_reset_mid;
    sw_in = 4'hA;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (phase !== 3'd0 || req_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid got phase=%0d valid=%0b busy=%0b exp 0/0/0", phase, req_valid, busy); end
    checks++; if (req_a !== 4'h0 || disp_value !== 4'hA) begin
      errors++; $display("FAIL rst_mid_regs got a=%h disp=%h exp 0/a", req_a, disp_value); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_abort;
    int r0;
    bit got;
    core_en = 1'b1; core_delay = 30; core_data = 4'hF; req_ready = 1'b1;
    sw_in = 4'h1; press(1'b1, 1'b0);
    sw_in = 4'h2; press(1'b1, 1'b0);
    op_in = 2'b11;
    r0 = rsp_done;
    press(1'b1, 1'b0);
    req_ready = 1'b0;
    checks++; if (phase !== 3'd4) begin errors++; $display("FAIL abort_wait got %0d exp 4", phase); end
    press(1'b0, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (rsp_done != r0) got = 1'b1;
      else tick(1);
    end
    checks++; if (!got) begin errors++; $display("FAIL abort_rsp_timeout got none exp 1 response"); end
    tick(3);
    checks++; if (phase !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_phase got phase=%0d busy=%0b exp 0/0", phase, busy); end
    checks++; if (dut.r_result !== 4'h0) begin errors++; $display("FAIL abort_result got %h exp 0", dut.r_result); end
    core_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_debounce();
    test_simultaneous();
    test_backpressure();
    test_reset_mid();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_operand_sequencer.md
# calc_operand_sequencer

Front-end sequencer for the 4-bit calculator core: turns slide-switch values and two push buttons into a complete calculation request (A, B, op), issues it with a valid/ready handshake, captures the result, and holds it for the display. It is the initiator side of the calculator request/response interface; the calculator core is the responder. It sits between the board I/O pins and the core.

## Interface
- `WIDTH`, 4, operand/result width in bits
- `DEBOUNCE_CYCLES`, 16, consecutive stable synchronized samples required before a button level is accepted (≥2)
- `clk` in 1, single clock
- `rst_n` in 1, asynchronous, active-low reset
- `sw_in` in WIDTH, operand switches (quasi-static, sampled on capture)
- `op_in` in 2, opcode switches: 00 add, 01 sub, 10 or, 11 not-equal
- `btn_enter` in 1, raw asynchronous button, advances the sequence
- `btn_clear` in 1, raw asynchronous button, aborts to operand-A entry
- `req_valid` out 1, request valid
- `req_ready` in 1, core accepts request
- `req_a`, `req_b` out WIDTH, captured operands
- `req_op` out 2, captured opcode
- `rsp_valid` in 1, one-cycle result strobe from core
- `rsp_data` in WIDTH, result
- `disp_value` out WIDTH, value for 7-segment driver
- `phase` out 3, current state encoding, drives status LEDs
- `busy` out 1, high in ISSUE and WAIT_RSP

## Operation
- Each button: 2-flop synchronizer → debounce counter → rising-edge detector → one-cycle pulse (`enter_p`, `clear_p`).
- Debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
- FSM states: GET_A(0), GET_B(1), GET_OP(2), ISSUE(3), WAIT_RSP(4), SHOW(5).
  - GET_A + enter_p: `req_a`←`sw_in`, → GET_B.
  - GET_B + enter_p: `req_b`←`sw_in`, → GET_OP.
  - GET_OP + enter_p: `req_op`←`op_in`, → ISSUE.
  - ISSUE: `req_valid`=1; on `req_ready`, → WAIT_RSP.
  - WAIT_RSP: on `rsp_valid`, result register←`rsp_data`, → SHOW.
  - SHOW + enter_p: → GET_A. Result is kept until the next capture.
- clear_p: → GET_A from every state except ISSUE, where it is ignored. A request is never withdrawn once `req_valid` is high.
- clear_p in WAIT_RSP: the FSM goes to GET_A and the pending response is discarded. A `rsp_valid` arriving outside WAIT_RSP is ignored.
- Simultaneous enter_p and clear_p: clear wins wherever clear is honored.
- enter_p in ISSUE or WAIT_RSP is ignored.
- `disp_value`: `sw_in` in GET_A/GET_B; `{2'b0,op_in}` zero-extended in GET_OP; `req_b` in ISSUE/WAIT_RSP; result register in SHOW.
- `req_a`, `req_b`, and `req_op` are stable whenever `req_valid` is high.

## Timing
- Reset values: state GET_A, `req_valid`=0, `req_a`=`req_b`=0, `req_op`=00, result=0, `busy`=0, `phase`=0, debounced levels=0, synchronizers=0.
- Button latency: raw level first sampled high at edge k, held stable → pulse high in cycle after edge k+DEBOUNCE_CYCLES+2 → state changes at edge k+DEBOUNCE_CYCLES+3.
- Release then re-press generates a new pulse only after release is itself debounced. Holding a button produces exactly one pulse.
- `req_valid` asserts the cycle after entering ISSUE. The handshake completes on the edge where `req_valid`&&`req_ready`. `req_valid` is low the following cycle.
- Result is captured on the `rsp_valid` edge and appears on `disp_value` the next cycle.
- Reset mid-operation: all of the above reset immediately (asynchronous assert), with synchronous deassert via the existing reset path.

## Structure
- Package `calc_pkg`:
  - `calc_op_t` (ADD, SUB, OR, NEQ as 2-bit enum)
  - `seq_state_t` (6 states, 3-bit, encodings as above)
  - the calculator core shares `calc_op_t`
- Sub-module `btn_debounce` (synchronizer, counter, edge pulse; parameter DEBOUNCE_CYCLES), instantiated twice.
- Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: `rst_n` low mid-WAIT_RSP → `phase`=0, `req_valid`=0, `disp_value`=`sw_in`, `req_a`=0 within the same cycle.
- Full sequence: enter with sw=3, enter with sw=5, enter with op=00; `req_ready` held high; core returns 8 two cycles later → one `req_valid` cycle with a=3, b=5, op=00; `disp_value`=8 in SHOW.
- Debounce: enter toggles every 2 cycles for 20 cycles, then held high → exactly one advance, occurring 7 edges after the last rising bounce.
- Backpressure: `req_ready` low for 10 cycles in ISSUE, with clear and enter pulsed meanwhile → `req_valid` stays high, a/b/op unchanged, state stays ISSUE; handshake on the first ready cycle.
- Abort: clear in WAIT_RSP, then `rsp_valid` with data 0xF → `phase`=0, result register unchanged (0), response ignored.
- Simultaneous: enter and clear pressed together in GET_B → FSM returns to GET_A, `req_b` not updated.
